sgdmac_read_mo: RTL and testbench

SGDMAC_READ_MO -- requirements
Module: sgdmac_read_mo

---
 rtl/sgdmac_read_mo.sv | 136 +++++++++++++
 tb/tb_sgdmac_read_mo.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgdmac_read_mo.sv
// Scatter-gather DMA read mover: splits a byte-count command into AXI INCR read bursts
// that never cross 4 KB, bounded by outstanding-burst count and pre-reserved buffer space.
module sgdmac_read_mo #(
  parameter int         DATA_W          = 32,
  parameter int         MAX_BURST       = 16,
  parameter int         MAX_OUTSTANDING = 4,
  parameter int         FIFO_DEPTH      = 64,
  parameter logic [3:0] AXI_ID          = 4'h0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [3:0]                    arid_o,
  output logic [31:0]                   araddr_o,
  output logic [3:0]                    arlen_o,
  output logic [2:0]                    arsize_o,
  output logic [1:0]                    arburst_o,
  output logic                          arvalid_o,
  input  logic                          arready_i,
  input  logic [3:0]                    rid_i,
  input  logic [DATA_W-1:0]             rdata_i,
  input  logic [1:0]                    rresp_i,
  input  logic                          rlast_i,
  input  logic                          rvalid_i,
  output logic                          rready_o,
  input  logic                          start_i,
  input  logic [47:0]                   cmd_i,
  output logic                          done_o,
  output logic                          err_o,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_free_i,
  output logic                          fifo_wren_o,
  output logic [DATA_W-1:0]             fifo_wdata_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int RW    = $clog2(MAX_OUTSTANDING * MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        state;
  logic [31:0]   addr;
  logic [15:0]   remaining;
  logic [OW-1:0] outstanding;
  logic [RW-1:0] reserved;
  logic          err;

  logic [12:0]   room_bytes;
  logic [12:0]   room_beats;
  logic [15:0]   blen;
  logic          can_issue;
  logic          ar_hs;
  logic          r_hs;
  logic [4:0]    ar_len;
  logic [15:0]   cmd_beats;
  logic          unused;

  assign room_bytes = 13'h1000 - {1'b0, addr[11:0]};
  assign room_beats = room_bytes >> LB;
  assign cmd_beats  = 16'(cmd_i[15:0] >> LB);

  always_comb begin
    blen = 16'(MAX_BURST);
    if (remaining < blen) blen = remaining;
    if ({3'b000, room_beats} < blen) blen = {3'b000, room_beats};
  end

  // A new AR is only launched when none is pending, so its fields stay frozen until arready.
  assign can_issue = (state == ISSUE) && !arvalid_o && (remaining != 16'd0) &&
                     (outstanding < OW'(MAX_OUTSTANDING)) && !err &&
                     (32'(fifo_free_i) >= 32'(reserved) + 32'(blen));

  assign ar_hs  = arvalid_o & arready_i;
  assign r_hs   = rvalid_i & rready_o;
  assign ar_len = {1'b0, arlen_o} + 5'd1;

  assign rready_o     = (outstanding != '0);
  assign fifo_wren_o  = r_hs & ~err & ~rresp_i[1];
  assign fifo_wdata_o = rdata_i;
  assign done_o       = (state == IDLE);
  assign err_o        = err;
  assign arid_o       = AXI_ID;
  assign arsize_o     = 3'(LB);
  assign arburst_o    = 2'b01;

  // Responses return in order, so the ID and the low response bit carry no information here.
  assign unused = &{1'b0, rid_i, rresp_i[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      outstanding <= '0;
      reserved    <= '0;
      err         <= 1'b0;
      arvalid_o   <= 1'b0;
      araddr_o    <= '0;
      arlen_o     <= '0;
    end else begin
      outstanding <= outstanding + OW'(ar_hs) - OW'(r_hs & rlast_i);
      reserved    <= reserved + (ar_hs ? RW'(ar_len) : '0) - RW'(r_hs);
      if (r_hs && rresp_i[1]) err <= 1'b1;
      if (ar_hs) begin
        arvalid_o <= 1'b0;
        addr      <= addr + (32'(ar_len) << LB);
        remaining <= remaining - 16'(ar_len);
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            addr      <= cmd_i[47:16] & ~32'(BYTES - 1);
            remaining <= cmd_beats;
            err       <= 1'b0;
            state     <= (cmd_beats == 16'd0) ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          if (can_issue) begin
            arvalid_o <= 1'b1;
            araddr_o  <= addr;
            arlen_o   <= 4'(blen - 16'd1);
          end else if (!arvalid_o && ((remaining == 16'd0) || err)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((outstanding == '0) && (reserved == '0)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sgdmac_read_mo.sv
// Bench for sgdmac_read_mo: in-order AXI read slave, burst-split model feeding AR/write scoreboards.
module tb_sgdmac_read_mo;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    arid_o;
  logic [31:0]   araddr_o;
  logic [3:0]    arlen_o;
  logic [2:0]    arsize_o;
  logic [1:0]    arburst_o;
  logic          arvalid_o;
  logic          arready;
  logic [3:0]    rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready_o;
  logic          start;
  logic [47:0]   cmd;
  logic          done_o;
  logic          err_o;
  logic [6:0]    fifo_free;
  logic          fifo_wren_o;
  logic [DW-1:0] fifo_wdata_o;

  always #5 clk = ~clk;

  sgdmac_read_mo dut (
    .clk(clk), .rst_n(rst_n),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready),
    .rid_i(rid), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid),
    .rready_o(rready_o), .start_i(start), .cmd_i(cmd), .done_o(done_o), .err_o(err_o),
    .fifo_free_i(fifo_free), .fifo_wren_o(fifo_wren_o), .fifo_wdata_o(fifo_wdata_o)
  );

  typedef struct { logic [31:0] src; logic [15:0] bytes; int n_ar; int n_wr; bit rnd; } vec_t;
  typedef struct { logic [31:0] a; logic [3:0] l; } burst_t;

  vec_t        vecs[8];
  burst_t      slv_q[$];
  logic [35:0] exp_ar[$];
  logic [31:0] exp_wr[$];
  int n_chk = 0, n_err = 0, n_ar = 0, n_wr = 0, n_rlast = 0;
  int bidx = 0, gbeat = 0, err_at = -1;
  bit r_en = 1'b1, ar_rnd = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input logic [63:0] act);
    n_chk++;
    n_err++;
    $display("FAIL %s: got 0x%0h, expected nothing", nm, act);
  endtask

  // Reference burst split: min(16, remaining, beats to 4 KB), data = beat address.
  task automatic push_model(input logic [31:0] src, input logic [15:0] bytes);
    logic [31:0] a;
    int rem, l, room;
    a = src & ~32'h3;
    rem = int'(bytes) / 4;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      l = 16;
      if (rem < l) l = rem;
      if (room < l) l = room;
      exp_ar.push_back({a, 4'(l - 1)});
      for (int b = 0; b < l; b++) exp_wr.push_back(a + 32'(4 * b));
      a = a + 32'(4 * l);
      rem = rem - l;
    end
  endtask

  // AXI slave: samples handshakes at the edge, drives new values 1 time unit later.
  initial begin : slave
    bit arh, rh;
    burst_t cap;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = 4'h0;
    forever begin
      @(posedge clk);
      arh = arvalid_o && arready;
      rh = rvalid && rready_o;
      cap.a = araddr_o;
      cap.l = arlen_o;
      #1;
      if (!rst_n) begin
        slv_q.delete();
        bidx = 0;
        rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
      end else begin
        if (arh) slv_q.push_back(cap);
        if (rh && slv_q.size() > 0) begin
          gbeat++;
          if (bidx == int'(slv_q[0].l)) begin
            void'(slv_q.pop_front());
            bidx = 0;
          end else bidx++;
        end
        arready = ar_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (r_en && slv_q.size() > 0) begin
          rvalid = 1'b1;
          rdata  = slv_q[0].a + 32'(bidx * 4);
          rlast  = (bidx == int'(slv_q[0].l));
          rresp  = (gbeat == err_at) ? 2'b10 : 2'b00;
        end else begin
          rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        end
      end
    end
  end

  initial begin : monitor
    bit pend;
    logic [35:0] prev;
    pend = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pend) chk("ar_hold", 64'({arvalid_o, araddr_o, arlen_o}), 64'({1'b1, prev}));
        pend = arvalid_o && !arready;
        prev = {araddr_o, arlen_o};
        if (arvalid_o && arready) begin
          n_ar++;
          chk("ar_fixed", 64'({arid_o, arsize_o, arburst_o}), 64'({4'h0, 3'd2, 2'b01}));
          if (exp_ar.size() == 0) fail_now("ar_unexpected", 64'(araddr_o));
          else chk("ar_addr_len", 64'({araddr_o, arlen_o}), 64'(exp_ar.pop_front()));
        end
        if (rvalid && rready_o && rlast) n_rlast++;
        if (fifo_wren_o) begin
          n_wr++;
          if (exp_wr.size() == 0) fail_now("wr_unexpected", 64'(fifo_wdata_o));
          else chk("wr_data", 64'(fifo_wdata_o), 64'(exp_wr.pop_front()));
        end
      end else pend = 1'b0;
    end
  end

  task automatic start_cmd(input logic [31:0] src, input logic [15:0] bytes);
    @(posedge clk); #1;
    start = 1'b1;
    cmd = {src, bytes};
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(done_o), 64'(0));
    chk("err_cleared", 64'(err_o), 64'(0));
  endtask

  task automatic wait_done(input int bound, input string nm);
    for (int i = 0; i < bound; i++) begin
      if (done_o) break;
      @(posedge clk); #1;
    end
    if (!done_o) fail_now({nm, "_timeout"}, 64'(done_o));
    @(negedge clk);
  endtask

  task automatic wait_ars(input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (n_ar >= target) break;
      @(posedge clk); #1;
    end
    if (n_ar < target) fail_now("ar_wait_timeout", 64'(n_ar));
  endtask

  task automatic run_cmd(input vec_t v, input string nm);
    int a0, w0;
    a0 = n_ar;
    w0 = n_wr;
    ar_rnd = v.rnd;
    push_model(v.src, v.bytes);
    start_cmd(v.src, v.bytes);
    wait_done(3000, nm);
    chk({nm, "_ar_count"}, 64'(n_ar - a0), 64'(v.n_ar));
    chk({nm, "_wr_count"}, 64'(n_wr - w0), 64'(v.n_wr));
    chk({nm, "_queues_empty"}, 64'(exp_ar.size() + exp_wr.size()), 64'(0));
    chk({nm, "_no_err"}, 64'(err_o), 64'(0));
    ar_rnd = 1'b0;
  endtask

  initial begin : main
    int a0, w0, l0;
    start = 1'b0; cmd = '0; fifo_free = 7'd64;
    vecs[0] = '{32'h1000, 16'd256,  4,  64, 1'b0};
    vecs[1] = '{32'h0FF0, 16'd64,   2,  16, 1'b0};
    vecs[2] = '{32'h0000, 16'd0,    0,   0, 1'b0};
    vecs[3] = '{32'h1FFC, 16'd8,    2,   2, 1'b1};
    vecs[4] = '{32'h4003, 16'd40,   1,  10, 1'b0};
    vecs[5] = '{32'h5000, 16'd67,   1,  16, 1'b1};
    vecs[6] = '{32'h6F80, 16'd600, 10, 150, 1'b1};
    vecs[7] = '{32'h3FC0, 16'd1024, 16, 256, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", 64'(arvalid_o), 64'(0));
    chk("rst_rready", 64'(rready_o), 64'(0));
    chk("rst_wren", 64'(fifo_wren_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(1));
    chk("rst_err", 64'(err_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Error on the 5th beat of the only burst allowed by 16 free entries.
    fifo_free = 7'd16;
    a0 = n_ar; w0 = n_wr;
    err_at = gbeat + 4;
    exp_ar.push_back({32'h2000, 4'd15});
    for (int b = 0; b < 4; b++) exp_wr.push_back(32'h2000 + 32'(4 * b));
    start_cmd(32'h2000, 16'd128);
    wait_done(2000, "err");
    chk("err_sticky", 64'(err_o), 64'(1));
    chk("err_ar_count", 64'(n_ar - a0), 64'(1));
    chk("err_wr_count", 64'(n_wr - w0), 64'(4));
    chk("err_queues_empty", 64'(exp_ar.size() + exp_wr.size()), 64'(0));
    err_at = -1;
    fifo_free = 7'd64;

    for (int i = 0; i < 8; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Outstanding limit: four bursts with R stalled, fifth only after an rlast.
    a0 = n_ar; w0 = n_wr; l0 = n_rlast;
    r_en = 1'b0;
    push_model(32'h8000, 16'd512);
    start_cmd(32'h8000, 16'd512);
    repeat (40) @(posedge clk);
    #1;
    chk("mo_limit", 64'(n_ar - a0), 64'(4));
    chk("mo_rready", 64'(rready_o), 64'(1));
    r_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (n_rlast > l0) break;
      @(posedge clk); #1;
    end
    r_en = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mo_after_rlast", 64'(n_ar - a0), 64'(5));
    r_en = 1'b1;
    wait_done(3000, "mo");
    chk("mo_wr_count", 64'(n_wr - w0), 64'(128));
    chk("mo_queues_empty", 64'(exp_ar.size() + exp_wr.size()), 64'(0));

    // Buffer reservation: second burst needs fifo_free >= 32.
    a0 = n_ar; w0 = n_wr;
    r_en = 1'b0;
    fifo_free = 7'd20;
    push_model(32'h9000, 16'd256);
    start_cmd(32'h9000, 16'd256);
    repeat (20) @(posedge clk);
    #1;
    chk("free20_ars", 64'(n_ar - a0), 64'(1));
    fifo_free = 7'd31;
    repeat (10) @(posedge clk);
    #1;
    chk("free31_ars", 64'(n_ar - a0), 64'(1));
    fifo_free = 7'd32;
    repeat (10) @(posedge clk);
    #1;
    chk("free32_ars", 64'(n_ar - a0), 64'(2));
    fifo_free = 7'd64;
    r_en = 1'b1;
    wait_done(3000, "free");
    chk("free_wr_count", 64'(n_wr - w0), 64'(64));
    chk("free_queues_empty", 64'(exp_ar.size() + exp_wr.size()), 64'(0));

    // Reset with two bursts outstanding, then a clean transfer.
    a0 = n_ar;
    r_en = 1'b0;
    push_model(32'hA000, 16'd256);
    start_cmd(32'hA000, 16'd256);
    wait_ars(a0 + 2, 100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_arvalid", 64'(arvalid_o), 64'(0));
    chk("mid_rst_rready", 64'(rready_o), 64'(0));
    chk("mid_rst_wren", 64'(fifo_wren_o), 64'(0));
    chk("mid_rst_done", 64'(done_o), 64'(1));
    chk("mid_rst_err", 64'(err_o), 64'(0));
    exp_ar.delete();
    exp_wr.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    r_en = 1'b1;
    run_cmd(vecs[0], "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
